exc_commit_ctrl: RTL
====================

Name: exc_commit_ctrl

Overview:
- Commit-stage exception and flush controller. It sits directly upstream of the CP0 register block.
- Takes one committing instruction per cycle and the CP0 interrupt-pending lines. Arbitrates interrupt, synchronous exception, ERET and privileged refetch.
- Drives the CP0 exception record (ex/exccode/bd/epc/badvaddr/tlb_refill) and the three flush sources as a single-cycle pulse.
- Then blocks commit for a drain window while the frontend redirects.

Parameters:
- DRAIN_CYCLES, 2, cycles commit stays blocked after a flush pulse (min 1).
- EXCCODE_INT, 5'h00, exccode reported for interrupts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  1  an instruction commits this cycle (only counted when commit_ready=1)
- commit_ready  out  1  controller accepts a commit
- commit_pc  in  32  PC of the committing instruction
- commit_is_branch  in  1  instruction has a delay slot
- commit_in_ds  in  1  instruction is a delay slot
- commit_exc  in  1  pipeline detected a synchronous exception
- commit_exccode  in  5  code for commit_exc
- commit_badvaddr  in  32  faulting address
- commit_tlb_refill  in  1  TLB miss is a refill (no matching entry)
- commit_is_eret  in  1  ERET
- commit_is_priv  in  1  TLBWI/TLBWR/TLBR/TLBP/CACHE/MTC0 needing refetch
- int_pending  in  8  {cp0_hw, cp0_sw} from CP0, already masked by IE/IM/EXL
- cp0_exl  in  1  Status.EXL
- ex  out  1  exception pulse to CP0
- exccode  out  5
- bd  out  1
- ex_epc  out  32
- badvaddr  out  32
- tlb_refill  out  1
- flush_exception  out  1
- flush_eret  out  1
- flush_priv  out  1

Behaviour:
- Reset values:
  - All outputs 0, except commit_ready=1.
  - State IDLE, drain counter 0, ds_branch_pc 0, int_q 0.
- int_q <= |int_pending & ~cp0_exl every cycle. This is a one-cycle synchroniser. Interrupts are judged on int_q only.
- ds_branch_pc: loaded with commit_pc on each accepted commit with commit_is_branch=1. Holds otherwise.
- EPC rule for an accepted commit:
  - commit_in_ds=1: epc = ds_branch_pc, bd=1.
  - Otherwise: epc = commit_pc, bd=0.
- Priority for an accepted commit, highest first:
  1. int_q=1: ex, exccode=EXCCODE_INT, badvaddr=0, tlb_refill=0.
  2. commit_exc=1: ex, exccode=commit_exccode, badvaddr=commit_badvaddr, tlb_refill=commit_tlb_refill.
  3. commit_is_eret=1: flush_eret only.
  4. commit_is_priv=1: flush_priv only. ex_epc = commit_pc+4; in a delay slot, ex_epc = ds_branch_pc+8.
  5. None of the above: no action.
- Any of cases 1–4 sets flush_exception for the ex cases only. Exactly one flush_* is high per pulse.
- An interrupt pre-empts the instruction: ERET/priv is not executed, and ex_epc = that instruction's EPC.
- States:
  - IDLE:
    - commit_ready=1.
    - An accepted commit hitting cases 1–4 → FLUSH. The outputs are registered, so they appear the next cycle (latency 1).
    - Otherwise stay.
  - FLUSH:
    - Exactly one cycle.
    - ex/flush_* and the payload high; commit_ready=0.
    - Load drain counter with DRAIN_CYCLES-1 → DRAIN.
  - DRAIN:
    - commit_ready=0; all pulse outputs 0.
    - Counter decrements each cycle; at 0 → IDLE.
    - DRAIN_CYCLES=1 gives one DRAIN cycle.
- Payload outputs (exccode, bd, ex_epc, badvaddr, tlb_refill) hold their last value outside FLUSH.
- A branch that is itself excepting still updates ds_branch_pc. Any flush leaves ds_branch_pc stale; this is harmless because the next committed instruction cannot be a delay slot.
- A commit presented while commit_ready=0 is ignored entirely, including the ds_branch_pc update.
- Reset in FLUSH or DRAIN returns to IDLE on the next edge. There is no partial pulse.
- ex_epc is 32-bit modulo-2^32 arithmetic; 0xFFFFFFFC+4 wraps to 0.

Test Plan:
1. **Plain commits.** Commit commit_pc=0x80000000, no flags -> no pulse, commit_ready stays 1.
2. **AdEL.** Commit exc, exccode=4, badvaddr=0x1003, pc=0xBFC00010 -> next cycle ex=1, flush_exception=1, exccode=4, ex_epc=0xBFC00010, bd=0. Then commit_ready=0 for 1+DRAIN_CYCLES cycles (3 total), then 1.
3. **Delay-slot exception.** Branch at 0x80001000 commits, then a delay slot with exc (exccode=0x0A) -> ex_epc=0x80001000, bd=1.
4. **Interrupt pre-empts ERET.** Raise int_pending=8'h80 with cp0_exl=0. Two cycles later commit ERET at 0x80002000 -> ex=1, exccode=0, ex_epc=0x80002000, flush_eret=0.
5. **EXL masking and ERET.** Same as 4 with cp0_exl=1 -> flush_eret=1 only, ex=0.
6. **Privileged refetch.** TLBWI at 0x80003000 in a delay slot of a branch at 0x80002FFC -> flush_priv=1, ex_epc=0x80003004. Then reset asserted during DRAIN -> commit_ready=1 the following cycle, all pulses 0.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/flush controller: arbitrates interrupt, synchronous exception,
// ERET and privileged refetch, pulses the CP0 exception record, then drains the pipe.
module exc_commit_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter logic [4:0]  EXCCODE_INT  = 5'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit_valid,
   output logic        commit_ready,
   input  logic [31:0] commit_pc,
   input  logic        commit_is_branch,
   input  logic        commit_in_ds,
   input  logic        commit_exc,
   input  logic [4:0]  commit_exccode,
   input  logic [31:0] commit_badvaddr,
   input  logic        commit_tlb_refill,
   input  logic        commit_is_eret,
   input  logic        commit_is_priv,
   input  logic [7:0]  int_pending,
   input  logic        cp0_exl,
   output logic        ex,
   output logic [4:0]  exccode,
   output logic        bd,
   output logic [31:0] ex_epc,
   output logic [31:0] badvaddr,
   output logic        tlb_refill,
   output logic        flush_exception,
   output logic        flush_eret,
   output logic        flush_priv
);

   localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   ds_pc_q, ds_pc_d;
   logic          int_q, int_d;
   logic          ready_q, ready_d;
   logic          ex_q, ex_d;
   logic          fexc_q, fexc_d;
   logic          feret_q, feret_d;
   logic          fpriv_q, fpriv_d;
   logic [4:0]    code_q, code_d;
   logic          bd_q, bd_d;
   logic [31:0]   epc_q, epc_d;
   logic [31:0]   bad_q, bad_d;
   logic          tlb_q, tlb_d;

   logic          accept;
   logic [31:0]   insn_epc;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ds_pc_d  = ds_pc_q;
      int_d    = |int_pending & ~cp0_exl;
      ready_d  = ready_q;
      ex_d     = 1'b0;
      fexc_d   = 1'b0;
      feret_d  = 1'b0;
      fpriv_d  = 1'b0;
      code_d   = code_q;
      bd_d     = bd_q;
      epc_d    = epc_q;
      bad_d    = bad_q;
      tlb_d    = tlb_q;
      accept   = commit_valid & ready_q;
      insn_epc = commit_in_ds ? ds_pc_q : commit_pc;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (commit_is_branch) ds_pc_d = commit_pc;
               // An interrupt pre-empts the instruction, so ERET/priv never execute under it.
               if (int_q) begin
                  ex_d   = 1'b1;
                  fexc_d = 1'b1;
                  code_d = EXCCODE_INT;
                  bd_d   = commit_in_ds;
                  epc_d  = insn_epc;
                  bad_d  = '0;
                  tlb_d  = 1'b0;
               end else if (commit_exc) begin
                  ex_d   = 1'b1;
                  fexc_d = 1'b1;
                  code_d = commit_exccode;
                  bd_d   = commit_in_ds;
                  epc_d  = insn_epc;
                  bad_d  = commit_badvaddr;
                  tlb_d  = commit_tlb_refill;
               end else if (commit_is_eret) begin
                  feret_d = 1'b1;
               end else if (commit_is_priv) begin
                  fpriv_d = 1'b1;
                  epc_d   = commit_in_ds ? ds_pc_q + 32'd8 : commit_pc + 32'd4;
               end
               if (int_q | commit_exc | commit_is_eret | commit_is_priv) begin
                  state_d = S_FLUSH;
                  ready_d = 1'b0;
               end
            end
         end
         S_FLUSH: begin
            cnt_d   = CW'(DRAIN_CYCLES - 1);
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ds_pc_q <= '0;
         int_q   <= 1'b0;
         ready_q <= 1'b1;
         ex_q    <= 1'b0;
         fexc_q  <= 1'b0;
         feret_q <= 1'b0;
         fpriv_q <= 1'b0;
         code_q  <= '0;
         bd_q    <= 1'b0;
         epc_q   <= '0;
         bad_q   <= '0;
         tlb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ds_pc_q <= ds_pc_d;
         int_q   <= int_d;
         ready_q <= ready_d;
         ex_q    <= ex_d;
         fexc_q  <= fexc_d;
         feret_q <= feret_d;
         fpriv_q <= fpriv_d;
         code_q  <= code_d;
         bd_q    <= bd_d;
         epc_q   <= epc_d;
         bad_q   <= bad_d;
         tlb_q   <= tlb_d;
      end
   end

   assign commit_ready    = ready_q;
   assign ex              = ex_q;
   assign exccode         = code_q;
   assign bd              = bd_q;
   assign ex_epc          = epc_q;
   assign badvaddr        = bad_q;
   assign tlb_refill      = tlb_q;
   assign flush_exception = fexc_q;
   assign flush_eret      = feret_q;
   assign flush_priv      = fpriv_q;

endmodule
